timer_controller: RTL and testbench

Controller for the CHIP-8 delay and sound timers. It divides the system clock into a 60 Hz tick, holds the 8-bit delay timer (DT) and sound timer (ST), and decrements both on each tick. It also arbitrates CPU writes (Fx15 sets DT, Fx18 sets ST) against tick decrements, and runs a small state machine that drives the beeper. It sits between the CPU execute stage and the audio output pin.

---
 rtl/timer_controller.sv | 112 +++++++++++
 tb/tb_timer_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/timer_controller.sv
// CHIP-8 delay/sound timer block: 60 Hz prescaler, DT/ST registers, write arbitration and beeper FSM.
// Optional square-wave tone output is enabled with the SOUND_TONE_EN macro.
module timer_controller #(
  parameter int TICK_DIV = 83333,
  parameter int TONE_DIV = 6250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halt,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic [7:0] rd_delay,
  output logic       delay_zero,
  output logic       tick,
  output logic       sound_on,
  output logic       beep
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  logic [PW-1:0] pre_reg;
  logic [7:0]    dt_reg;
  logic [7:0]    st_reg;
  logic [7:0]    dt_next;
  logic [7:0]    st_next;
  state_t        state_reg;
  logic          tick_edge;

  assign tick_edge = (pre_reg == PRE_LAST) && !halt;

  // A write to a timer wins over that timer's decrement on the same edge.
  always_comb begin
    dt_next = dt_reg;
    st_next = st_reg;
    if (tick_edge && (dt_reg != 8'd0)) dt_next = dt_reg - 8'd1;
    if (tick_edge && (st_reg != 8'd0)) st_next = st_reg - 8'd1;
    if (wr_en && !wr_sel) dt_next = wr_data;
    if (wr_en &&  wr_sel) st_next = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_reg   <= '0;
      dt_reg    <= 8'd0;
      st_reg    <= 8'd0;
      tick      <= 1'b0;
      wr_ack    <= 1'b0;
      state_reg <= IDLE;
      sound_on  <= 1'b0;
    end else begin
      if (!halt) pre_reg <= (pre_reg == PRE_LAST) ? '0 : pre_reg + 1'b1;
      dt_reg <= dt_next;
      st_reg <= st_next;
      tick   <= tick_edge;
      wr_ack <= wr_en;
      case (state_reg)
        IDLE: begin
          if (st_reg != 8'd0) begin
            state_reg <= PLAY;
            sound_on  <= 1'b1;
          end
        end
        PLAY: begin
          if (st_reg == 8'd0) begin
            state_reg <= IDLE;
            sound_on  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          sound_on  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_delay   = dt_reg;
  assign delay_zero = (dt_reg == 8'd0);

`ifdef SOUND_TONE_EN
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

  logic [TW-1:0] tone_reg;

  // Tone phase restarts on every PLAY entry; leaving PLAY silences the pin on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tone_reg <= '0;
      beep     <= 1'b0;
    end else if (state_reg == PLAY && st_reg != 8'd0) begin
      if (tone_reg == TONE_LAST) begin
        tone_reg <= '0;
        beep     <= ~beep;
      end else begin
        tone_reg <= tone_reg + 1'b1;
      end
    end else begin
      tone_reg <= '0;
      beep     <= 1'b0;
    end
  end
`else
  assign beep = sound_on;
`endif

endmodule

// File: tb/tb_timer_controller.sv
// Directed + randomized bench for timer_controller against a per-edge arithmetic reference model.
module tb_timer_controller;
  localparam int TICK_DIV = 4;
  localparam int TONE_DIV = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       halt = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_ack;
  logic [7:0] rd_delay;
  logic       delay_zero;
  logic       tick;
  logic       sound_on;
  logic       beep;

  timer_controller #(.TICK_DIV(TICK_DIV), .TONE_DIV(TONE_DIV)) dut (
    .clk(clk), .reset(reset), .halt(halt), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_ack(wr_ack), .rd_delay(rd_delay), .delay_zero(delay_zero),
    .tick(tick), .sound_on(sound_on), .beep(beep)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: prescaler phase, timer values, whether sound is playing and how long.
  int m_pre = 0, m_dt = 0, m_st = 0, m_play = 0, m_tick = 0, m_ack = 0, m_age = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_beep();
`ifdef SOUND_TONE_EN
    return m_play ? ((m_age / TONE_DIV) % 2) : 0;
`else
    return m_play;
`endif
  endfunction

  task automatic model_edge();
    int fire, was_playing;
    if (!reset) begin
      m_pre = 0; m_dt = 0; m_st = 0; m_play = 0; m_tick = 0; m_ack = 0; m_age = 0;
    end else begin
      fire = (m_pre == TICK_DIV - 1) && !halt;
      was_playing = m_play;
      m_play = (m_st != 0);
      m_age  = (m_play && was_playing) ? m_age + 1 : 0;
      if (fire && m_dt > 0) m_dt = m_dt - 1;
      if (fire && m_st > 0) m_st = m_st - 1;
      if (wr_en && !wr_sel) m_dt = wr_data;
      if (wr_en &&  wr_sel) m_st = wr_data;
      if (!halt) m_pre = (m_pre + 1) % TICK_DIV;
      m_tick = fire;
      m_ack  = wr_en;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("tick", tick, m_tick);
    chk("wr_ack", wr_ack, m_ack);
    chk("rd_delay", rd_delay, m_dt);
    chk("delay_zero", delay_zero, (m_dt == 0));
    chk("sound_on", sound_on, m_play);
    chk("beep", beep, exp_beep());
  endtask

  task automatic write(input logic sel, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    step();
    wr_en = 1'b0;
    chk("wr_ack_pulse", wr_ack, 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // 1. Reset with a write strobe present, then free-running tick cadence.
    reset = 1'b0; wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ack", wr_ack, 0);
      chk("rst_dz", delay_zero, 1);
    end
    reset = 1'b1; wr_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("tick_seq", tick, (i % 4 == 3) ? 1 : 0);
    end

    // 2. DT countdown to zero, then holds.
    write(1'b0, 8'd3);
    chk("dt_load", rd_delay, 3);
    run(TICK_DIV * 8);
    chk("dt_floor", rd_delay, 0);
    chk("dt_floor_dz", delay_zero, 1);

    // 3. Write DT on a tick edge while ST counts.
    write(1'b1, 8'd2);
    while (m_pre != TICK_DIV - 1) step();
    write(1'b0, 8'd9);
    chk("collide_dt", rd_delay, 9);
    run(20);

    // 4. Sound of two ticks.
    write(1'b1, 8'd2);
    step();
    chk("sound_rise", sound_on, 1);
    run(12);
    chk("sound_done", sound_on, 0);

    // 5. Halt freezes the prescaler and timers.
    write(1'b0, 8'd5);
    halt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_tick", tick, 0);
      chk("halt_dt", rd_delay, 5);
    end
    halt = 1'b0;
    run(12);

    // 6. Overwrite ST=0 mid-play, then reset mid-play.
    write(1'b1, 8'd200);
    run(5);
    write(1'b1, 8'd0);
    step();
    chk("ovr_sound", sound_on, 0);
    chk("ovr_beep", beep, 0);
    write(1'b1, 8'd200);
    run(3);
    reset = 1'b0;
    step();
    chk("mid_rst_sound", sound_on, 0);
    chk("mid_rst_beep", beep, 0);
    reset = 1'b1;
    run(4);

    // 7. Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(99) != 0);
      halt    = ($urandom_range(9) == 0);
      wr_en   = ($urandom_range(6) == 0);
      wr_sel  = $urandom_range(1);
      wr_data = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(4));
      step();
    end
    reset = 1'b1; halt = 1'b0; wr_en = 1'b0;
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
